// File: rtl/duel_controller.sv
// duel_controller: two-player duel game sequencer with one shared projectile.
//
// The shared projectile flies for FLIGHT cycles. It then resolves against the
// opponent's current lane. A hit costs the target one life, and the game ends
// when a player runs out of lives.
//
// Ports:
//   CLK              rising-edge clock
//   RST              asynchronous, active-high reset
//   START            start / restart request (acted on in IDLE and OVER only)
//   FIRE1, FIRE2     level-sampled fire requests (acted on in READY only)
//   POS1, POS2       ship lanes, one-hot {R,C,L}
//   BUSY             projectile in flight
//   OWNER            owner of current/last projectile (0 = P1, 1 = P2)
//   SHOT_POS         lane of current/last projectile
//   HIT1, HIT2       one-cycle hit pulses
//   LIFE1, LIFE2     remaining lives
//   DONE, WINNER     game over and winning player (0 = P1, 1 = P2)
//
// Configuration macro:
//   DUEL_ROUND_ROBIN_EN  when defined, simultaneous fire requests alternate
//                        between the players. When undefined, P1 always wins.
//
// state   | meaning
// --------+-----------------------------------------------
// IDLE    | after reset, waiting for START
// READY   | game running, waiting for a fire request
// FLY     | projectile in flight, counter running down
// RESOLVE | compare shot lane with target lane, apply hit
// OVER    | a player has no lives left, waiting for START
module duel_controller #(
  parameter int FLIGHT = 4,
  parameter int LIVES  = 3
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       FIRE1,
  input  logic       FIRE2,
  input  logic [2:0] POS1,
  input  logic [2:0] POS2,
  output logic       BUSY,
  output logic       OWNER,
  output logic [2:0] SHOT_POS,
  output logic       HIT1,
  output logic       HIT2,
  output logic [1:0] LIFE1,
  output logic [1:0] LIFE2,
  output logic       DONE,
  output logic       WINNER
);

  typedef enum logic [2:0] {S_IDLE, S_READY, S_FLY, S_RESOLVE, S_OVER} state_t;

  localparam logic [3:0] CNT_INIT  = 4'(FLIGHT - 1);
  localparam logic [1:0] LIFE_INIT = 2'(LIVES);

  state_t     state;
  logic [3:0] cnt;
  logic       any_fire;
  logic       grant_p2;
  logic [2:0] target_pos;
  logic [1:0] target_life;
  logic [1:0] life_next;
  logic       is_hit;

  assign any_fire = FIRE1 | FIRE2;

`ifdef DUEL_ROUND_ROBIN_EN
  // Set when P2 should win the next simultaneous request. It is cleared by
  // reset, so P1 wins first.
  logic rr_p2;
  assign grant_p2 = FIRE2 & (~FIRE1 | rr_p2);

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rr_p2 <= 1'b0;
    end else if (state == S_READY && any_fire) begin
      rr_p2 <= ~grant_p2;
    end
  end
`else
  assign grant_p2 = FIRE2 & ~FIRE1;
`endif

  // The target lane is sampled live during RESOLVE. A zero lane never overlaps,
  // so a zero lane never hits and is never hit.
  assign target_pos  = OWNER ? POS1 : POS2;
  assign target_life = OWNER ? LIFE1 : LIFE2;
  assign is_hit      = |(SHOT_POS & target_pos);
  assign life_next   = (target_life == 2'd0) ? 2'd0 : target_life - 2'd1;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state    <= S_IDLE;
      cnt      <= 4'd0;
      BUSY     <= 1'b0;
      OWNER    <= 1'b0;
      SHOT_POS <= 3'b000;
      HIT1     <= 1'b0;
      HIT2     <= 1'b0;
      LIFE1    <= 2'd0;
      LIFE2    <= 2'd0;
      DONE     <= 1'b0;
      WINNER   <= 1'b0;
    end else begin
      HIT1 <= 1'b0;
      HIT2 <= 1'b0;
      case (state)
        S_IDLE: begin
          if (START) begin
            LIFE1 <= LIFE_INIT;
            LIFE2 <= LIFE_INIT;
            state <= S_READY;
          end
        end
        S_READY: begin
          if (any_fire) begin
            OWNER    <= grant_p2;
            SHOT_POS <= grant_p2 ? POS2 : POS1;
            cnt      <= CNT_INIT;
            BUSY     <= 1'b1;
            state    <= S_FLY;
          end
        end
        S_FLY: begin
          if (cnt == 4'd0) begin
            BUSY  <= 1'b0;
            state <= S_RESOLVE;
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        S_RESOLVE: begin
          if (is_hit) begin
            if (OWNER) begin
              HIT1  <= 1'b1;
              LIFE1 <= life_next;
            end else begin
              HIT2  <= 1'b1;
              LIFE2 <= life_next;
            end
          end
          if (is_hit && life_next == 2'd0) begin
            DONE   <= 1'b1;
            WINNER <= OWNER;
            state  <= S_OVER;
          end else begin
            state <= S_READY;
          end
        end
        S_OVER: begin
          if (START) begin
            LIFE1 <= LIFE_INIT;
            LIFE2 <= LIFE_INIT;
            DONE  <= 1'b0;
            state <= S_READY;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_duel_controller.sv
// tb_duel_controller: directed bench for duel_controller with FLIGHT=4 and LIVES=3.
// Inputs change 1 ns after each rising edge, and outputs are checked at the same point.
module tb_duel_controller;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       START = 1'b0;
  logic       FIRE1 = 1'b0;
  logic       FIRE2 = 1'b0;
  logic [2:0] POS1 = 3'b000;
  logic [2:0] POS2 = 3'b000;
  logic       BUSY, OWNER, HIT1, HIT2, DONE, WINNER;
  logic [2:0] SHOT_POS;
  logic [1:0] LIFE1, LIFE2;

  int checks = 0;
  int errors = 0;
  int busy_cnt;

  duel_controller #(.FLIGHT(4), .LIVES(3)) dut (
    .CLK(CLK), .RST(RST), .START(START), .FIRE1(FIRE1), .FIRE2(FIRE2),
    .POS1(POS1), .POS2(POS2), .BUSY(BUSY), .OWNER(OWNER), .SHOT_POS(SHOT_POS),
    .HIT1(HIT1), .HIT2(HIT2), .LIFE1(LIFE1), .LIFE2(LIFE2),
    .DONE(DONE), .WINNER(WINNER)
  );

  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Grant on the first edge, then FLIGHT cycles of flight, then RESOLVE.
  // The hit pulse is visible on return.
  task automatic shoot(input logic f1, input logic f2);
    FIRE1 = f1; FIRE2 = f2;
    step();
    FIRE1 = 1'b0; FIRE2 = 1'b0;
    repeat (5) step();
  endtask

  initial begin
    #1;
    check("rst_busy", {7'd0, BUSY}, 8'd0);
    check("rst_owner", {7'd0, OWNER}, 8'd0);
    check("rst_shot", {5'd0, SHOT_POS}, 8'd0);
    check("rst_lives", {4'd0, LIFE1, LIFE2}, 8'd0);
    check("rst_done_win_hit", {4'd0, DONE, WINNER, HIT1, HIT2}, 8'd0);
    step();
    RST = 1'b0;
    FIRE1 = 1'b1;
    step();
    FIRE1 = 1'b0;
    check("idle_ignores_fire", {7'd0, BUSY}, 8'd0);
    START = 1'b1;
    step();
    START = 1'b0;
    check("start_lives", {4'd0, LIFE1, LIFE2}, {4'd0, 2'd3, 2'd3});

    // First shot: P1 hits P2 in the centre lane.
    POS1 = 3'b010; POS2 = 3'b010;
    FIRE1 = 1'b1;
    step();
    FIRE1 = 1'b0;
    check("shot1_owner", {7'd0, OWNER}, 8'd0);
    check("shot1_pos", {5'd0, SHOT_POS}, 8'h02);
    busy_cnt = 0;
    for (int i = 0; i < 10 && BUSY; i++) begin
      busy_cnt++;
      step();
    end
    check("shot1_busy_cycles", 8'(busy_cnt), 8'd4);
    check("shot1_no_early_hit", {7'd0, HIT2}, 8'd0);
    step();
    check("shot1_hit2", {6'd0, HIT1, HIT2}, 8'h01);
    check("shot1_life2", {6'd0, LIFE2}, 8'd2);
    step();
    check("shot1_hit2_pulse_end", {7'd0, HIT2}, 8'd0);

    // P2 misses P1.
    POS1 = 3'b100; POS2 = 3'b001;
    shoot(1'b0, 1'b1);
    check("miss_owner", {7'd0, OWNER}, 8'd1);
    check("miss_shot", {5'd0, SHOT_POS}, 8'h01);
    check("miss_no_hit1", {7'd0, HIT1}, 8'd0);
    check("miss_life1", {6'd0, LIFE1}, 8'd3);

    // Two more P1 hits end the game.
    POS1 = 3'b010; POS2 = 3'b010;
    shoot(1'b1, 1'b0);
    check("hit2_life2", {6'd0, LIFE2}, 8'd1);
    check("hit2_not_done", {7'd0, DONE}, 8'd0);
    shoot(1'b1, 1'b0);
    check("kill_life2", {6'd0, LIFE2}, 8'd0);
    check("kill_done", {7'd0, DONE}, 8'd1);
    check("kill_winner", {7'd0, WINNER}, 8'd0);
    FIRE1 = 1'b1; FIRE2 = 1'b1;
    step();
    step();
    FIRE1 = 1'b0; FIRE2 = 1'b0;
    check("over_fire_ignored", {7'd0, BUSY}, 8'd0);
    check("over_lives_held", {4'd0, LIFE1, LIFE2}, {4'd0, 2'd3, 2'd0});
    START = 1'b1;
    step();
    START = 1'b0;
    check("restart_lives", {4'd0, LIFE1, LIFE2}, {4'd0, 2'd3, 2'd3});
    check("restart_done", {7'd0, DONE}, 8'd0);

    // Simultaneous requests after a fresh reset. Lanes are chosen so every shot misses.
    RST = 1'b1;
    step();
    RST = 1'b0;
    START = 1'b1;
    step();
    START = 1'b0;
    POS1 = 3'b001; POS2 = 3'b100;
    FIRE1 = 1'b1; FIRE2 = 1'b1;
    step();
    check("arb_grant1", {7'd0, OWNER}, 8'd0);
    repeat (5) step();
    step();
`ifdef DUEL_ROUND_ROBIN_EN
    check("arb_grant2", {7'd0, OWNER}, 8'd1);
`else
    check("arb_grant2", {7'd0, OWNER}, 8'd0);
`endif
    repeat (5) step();
    step();
    check("arb_grant3", {7'd0, OWNER}, 8'd0);
    FIRE1 = 1'b0; FIRE2 = 1'b0;
    repeat (5) step();
    check("arb_lives_kept", {4'd0, LIFE1, LIFE2}, {4'd0, 2'd3, 2'd3});

    // A hit-bound P1 shot with fire requests held mid-flight, then reset.
    POS1 = 3'b010; POS2 = 3'b010;
    FIRE1 = 1'b1;
    step();
    FIRE1 = 1'b1; FIRE2 = 1'b1;
    POS1 = 3'b100; POS2 = 3'b010;
    step();
    step();
    check("fly_no_regrant_owner", {7'd0, OWNER}, 8'd0);
    check("fly_no_regrant_pos", {5'd0, SHOT_POS}, 8'h02);
    check("fly_busy", {7'd0, BUSY}, 8'd1);
    FIRE1 = 1'b0; FIRE2 = 1'b0;
    RST = 1'b1;
    #1;
    check("async_rst_busy", {7'd0, BUSY}, 8'd0);
    check("async_rst_lives", {4'd0, LIFE1, LIFE2}, 8'd0);
    step();
    step();
    check("rst_no_hit", {6'd0, HIT1, HIT2}, 8'd0);
    RST = 1'b0;
    step();
    check("idle_after_rst", {7'd0, BUSY}, 8'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
